instr_sequencer: RTL and testbench

Multi-cycle sequencer for the single-issue RV32 core. Owns the PC and fetches instructions from instruction memory over a valid/ready request channel. Holds the fetched word stable for the combinational decoder, steps the datapath through decode/execute/writeback, and gates the register-file write with the decoder's write-enable. Sits between the imem interface and the decode/execute datapath; it is the only block that advances the PC.

---
 rtl/instr_sequencer_if.sv | 26 ++
 rtl/instr_sequencer.sv | 169 ++++++++++++++++
 tb/tb_instr_sequencer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_sequencer_if.sv
// rtl/instr_sequencer_if.sv - instruction memory request/response channel
interface instr_sequencer_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  // sequencer side: issues requests, consumes responses
  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  // memory side: accepts requests, returns instruction words
  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multi-cycle RV32 fetch/decode/execute/writeback sequencer (optional SEQ_PERF_CNT_EN counters)
module instr_sequencer #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  instr_sequencer_if.master  imem,
  output logic [31:0]        instr,
  input  logic [6:0]         opcode,
  input  logic               reg_write_en,
  output logic               rf_we,
  output logic [31:0]        pc,
  output logic [2:0]         state,
  output logic               halt,
  output logic               illegal
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        instret
`endif
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FETCH_REQ  = 3'd1,
    S_FETCH_WAIT = 3'd2,
    S_DECODE     = 3'd3,
    S_EXECUTE    = 3'd4,
    S_WRITEBACK  = 3'd5,
    S_HALT       = 3'd6
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [6:0]  OP_IMM    = 7'h13;
  localparam logic [6:0]  OP_REG    = 7'h33;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        req_valid_q;
  logic        rf_we_q;
  logic        halt_q;
  logic        illegal_q;
  logic        legal_op;

  // the decoder sees instr_q, so opcode is meaningful while in DECODE
  assign legal_op = (opcode == OP_IMM) || (opcode == OP_REG);

  assign imem.imem_req_valid = req_valid_q;
  assign imem.imem_addr      = pc_q;
  assign instr               = instr_q;
  assign pc                  = pc_q;
  assign state               = state_q;
  assign rf_we               = rf_we_q;
  assign halt                = halt_q;
  assign illegal             = illegal_q;

  // main sequencer FSM; every output is a register so downstream sees clean levels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      instr_q     <= NOP_INSTR;
      req_valid_q <= 1'b0;
      rf_we_q     <= 1'b0;
      halt_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      // write strobe is a single-cycle pulse unless EXECUTE arms it below
      rf_we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          req_valid_q <= 1'b0;
          if (run) begin
            state_q     <= S_FETCH_REQ;
            req_valid_q <= 1'b1;
          end
        end

        S_FETCH_REQ: begin
          // request held until accepted; responses here are not ours
          if (req_valid_q && imem.imem_req_ready) begin
            state_q     <= S_FETCH_WAIT;
            req_valid_q <= 1'b0;
          end
        end

        S_FETCH_WAIT: begin
          if (imem.imem_rsp_valid) begin
            instr_q <= imem.imem_rsp_data;
            state_q <= S_DECODE;
          end
        end

        S_DECODE: begin
          if (legal_op) begin
            state_q <= S_EXECUTE;
          end else begin
            illegal_q <= 1'b1;
            if (HALT_ON_ILLEGAL) begin
              state_q <= S_HALT;
              halt_q  <= 1'b1;
            end else begin
              // skip as a NOP: WRITEBACK with the strobe left low
              state_q <= S_WRITEBACK;
            end
          end
        end

        S_EXECUTE: begin
          state_q <= S_WRITEBACK;
          rf_we_q <= reg_write_en;
        end

        S_WRITEBACK: begin
          pc_q <= pc_q + 32'd4;
          if (run) begin
            state_q     <= S_FETCH_REQ;
            req_valid_q <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end

        S_HALT: begin
          req_valid_q <= 1'b0;
          halt_q      <= 1'b1;
        end

        default: begin
          state_q     <= S_IDLE;
          req_valid_q <= 1'b0;
          halt_q      <= 1'b0;
        end
      endcase
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cycle_cnt_q;
  logic [31:0] instret_q;
  logic        skip_q;

  assign cycle_cnt = cycle_cnt_q;
  assign instret   = instret_q;

  // busy-cycle and retired-instruction counters, both free-running wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt_q <= 32'd0;
      instret_q   <= 32'd0;
      skip_q      <= 1'b0;
    end else begin
      if (state_q != S_IDLE && state_q != S_HALT) begin
        cycle_cnt_q <= cycle_cnt_q + 32'd1;
      end
      if (state_q == S_DECODE) begin
        skip_q <= !legal_op;
      end
      if (state_q == S_WRITEBACK && !skip_q) begin
        instret_q <= instret_q + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed bench for instr_sequencer
module tb_instr_sequencer;

  localparam logic [31:0] ADDI = 32'h0050_0093;
  localparam logic [31:0] BAD  = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nerr = 0;
  int nchk = 0;

  // DUT A: RESET_PC=0x100, halts on illegal
  logic        rst_a, run_a, rf_we_a, halt_a, ill_a;
  logic [31:0] instr_a, pc_a;
  logic [6:0]  op_a;
  logic [2:0]  st_a;
  instr_sequencer_if if_a ();
  assign op_a = instr_a[6:0];

  // DUT B: RESET_PC=0xFFFFFFFC, skips illegal
  logic        rst_b, run_b, rf_we_b, halt_b, ill_b;
  logic [31:0] instr_b, pc_b;
  logic [6:0]  op_b;
  logic [2:0]  st_b;
  instr_sequencer_if if_b ();
  assign op_b = instr_b[6:0];

  logic rwe;

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cyc_a, ret_a, cyc_b, ret_b;
`endif

  instr_sequencer #(.RESET_PC(32'h0000_0100), .HALT_ON_ILLEGAL(1'b1)) dut_a (
    .clk(clk), .rst(rst_a), .run(run_a), .imem(if_a),
    .instr(instr_a), .opcode(op_a), .reg_write_en(rwe), .rf_we(rf_we_a),
    .pc(pc_a), .state(st_a), .halt(halt_a), .illegal(ill_a)
`ifdef SEQ_PERF_CNT_EN
    , .cycle_cnt(cyc_a), .instret(ret_a)
`endif
  );

  instr_sequencer #(.RESET_PC(32'hFFFF_FFFC), .HALT_ON_ILLEGAL(1'b0)) dut_b (
    .clk(clk), .rst(rst_b), .run(run_b), .imem(if_b),
    .instr(instr_b), .opcode(op_b), .reg_write_en(rwe), .rf_we(rf_we_b),
    .pc(pc_b), .state(st_b), .halt(halt_b), .illegal(ill_b)
`ifdef SEQ_PERF_CNT_EN
    , .cycle_cnt(cyc_b), .instret(ret_b)
`endif
  );

  typedef struct {
    logic        run;
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic [2:0]  st;
    logic        req;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        we;
    logic        hlt;
    logic        ill;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mk(logic run, logic rdy, logic rv, logic [31:0] rd,
                              logic [2:0] st, logic req, logic [31:0] pc,
                              logic [31:0] ins, logic we, logic hlt, logic ill);
    vec_t v;
    v.run = run; v.rdy = rdy; v.rv = rv; v.rd = rd;
    v.st = st; v.req = req; v.pc = pc; v.instr = ins;
    v.we = we; v.hlt = hlt; v.ill = ill;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // cycle-by-cycle vectors for DUT A; expectations are sampled just after the edge
    tbl[0]  = mk(1, 1, 0, 32'h0,  3'd1, 1, 32'h100, NOP,  0, 0, 0);
    tbl[1]  = mk(1, 1, 0, 32'h0,  3'd2, 0, 32'h100, NOP,  0, 0, 0);
    tbl[2]  = mk(1, 1, 1, ADDI,   3'd3, 0, 32'h100, ADDI, 0, 0, 0);
    tbl[3]  = mk(1, 1, 0, 32'h0,  3'd4, 0, 32'h100, ADDI, 0, 0, 0);
    tbl[4]  = mk(1, 1, 0, 32'h0,  3'd5, 0, 32'h100, ADDI, 1, 0, 0);
    tbl[5]  = mk(1, 1, 0, 32'h0,  3'd1, 1, 32'h104, ADDI, 0, 0, 0);
    tbl[6]  = mk(1, 1, 0, 32'h0,  3'd2, 0, 32'h104, ADDI, 0, 0, 0);
    tbl[7]  = mk(1, 1, 1, ADDI,   3'd3, 0, 32'h104, ADDI, 0, 0, 0);
    tbl[8]  = mk(1, 1, 0, 32'h0,  3'd4, 0, 32'h104, ADDI, 0, 0, 0);
    tbl[9]  = mk(1, 1, 0, 32'h0,  3'd5, 0, 32'h104, ADDI, 1, 0, 0);
    tbl[10] = mk(1, 0, 0, 32'h0,  3'd1, 1, 32'h108, ADDI, 0, 0, 0);
    tbl[11] = mk(1, 0, 1, 32'hDEADBEEF, 3'd1, 1, 32'h108, ADDI, 0, 0, 0);
    tbl[12] = mk(1, 0, 0, 32'h0,  3'd1, 1, 32'h108, ADDI, 0, 0, 0);
    tbl[13] = mk(1, 0, 0, 32'h0,  3'd1, 1, 32'h108, ADDI, 0, 0, 0);
    tbl[14] = mk(1, 1, 0, 32'h0,  3'd2, 0, 32'h108, ADDI, 0, 0, 0);
    tbl[15] = mk(1, 1, 1, BAD,    3'd3, 0, 32'h108, BAD,  0, 0, 0);
    tbl[16] = mk(1, 1, 0, 32'h0,  3'd6, 0, 32'h108, BAD,  0, 1, 1);
    tbl[17] = mk(1, 1, 1, ADDI,   3'd6, 0, 32'h108, BAD,  0, 1, 1);
    tbl[18] = mk(1, 1, 0, 32'h0,  3'd6, 0, 32'h108, BAD,  0, 1, 1);

    rwe = 1'b1;
    rst_a = 1'b0; run_a = 1'b0;
    rst_b = 1'b0; run_b = 1'b0;
    if_a.imem_req_ready = 1'b0; if_a.imem_rsp_valid = 1'b0; if_a.imem_rsp_data = 32'h0;
    if_b.imem_req_ready = 1'b0; if_b.imem_rsp_valid = 1'b0; if_b.imem_rsp_data = 32'h0;
    #1;
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (2) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    #1;

    chk("reset state",   {29'd0, st_a}, 32'd0);
    chk("reset pc",      pc_a, 32'h100);
    chk("reset addr",    if_a.imem_addr, 32'h100);
    chk("reset instr",   instr_a, NOP);
    chk("reset req",     {31'd0, if_a.imem_req_valid}, 32'd0);
    chk("reset rf_we",   {31'd0, rf_we_a}, 32'd0);
    chk("reset halt",    {31'd0, halt_a}, 32'd0);
    chk("reset illegal", {31'd0, ill_a}, 32'd0);
    chk("reset pc b",    pc_b, 32'hFFFF_FFFC);
`ifdef SEQ_PERF_CNT_EN
    chk("reset cycle_cnt", cyc_a, 32'd0);
    chk("reset instret",   ret_a, 32'd0);
`endif

    for (int i = 0; i < 19; i++) begin
      run_a = tbl[i].run;
      if_a.imem_req_ready = tbl[i].rdy;
      if_a.imem_rsp_valid = tbl[i].rv;
      if_a.imem_rsp_data  = tbl[i].rd;
      step();
      chk($sformatf("row%0d state", i),   {29'd0, st_a}, {29'd0, tbl[i].st});
      chk($sformatf("row%0d req", i),     {31'd0, if_a.imem_req_valid}, {31'd0, tbl[i].req});
      chk($sformatf("row%0d pc", i),      pc_a, tbl[i].pc);
      chk($sformatf("row%0d addr", i),    if_a.imem_addr, tbl[i].pc);
      chk($sformatf("row%0d instr", i),   instr_a, tbl[i].instr);
      chk($sformatf("row%0d rf_we", i),   {31'd0, rf_we_a}, {31'd0, tbl[i].we});
      chk($sformatf("row%0d halt", i),    {31'd0, halt_a}, {31'd0, tbl[i].hlt});
      chk($sformatf("row%0d illegal", i), {31'd0, ill_a}, {31'd0, tbl[i].ill});
    end

    // DUT B: pc wrap plus run dropped during EXECUTE
    run_b = 1'b1; if_b.imem_req_ready = 1'b1;
    step();
    chk("b fetch_req state", {29'd0, st_b}, 32'd1);
    chk("b first addr", if_b.imem_addr, 32'hFFFF_FFFC);
    step();
    chk("b fetch_wait state", {29'd0, st_b}, 32'd2);
    if_b.imem_rsp_valid = 1'b1; if_b.imem_rsp_data = ADDI;
    step();
    if_b.imem_rsp_valid = 1'b0;
    chk("b decode instr", instr_b, ADDI);
    step();
    chk("b execute state", {29'd0, st_b}, 32'd4);
    run_b = 1'b0;
    step();
    chk("b wb state", {29'd0, st_b}, 32'd5);
    chk("b wb rf_we", {31'd0, rf_we_b}, 32'd1);
    step();
    chk("b idle after run drop", {29'd0, st_b}, 32'd0);
    chk("b pc wrap", pc_b, 32'd0);
    chk("b rf_we single pulse", {31'd0, rf_we_b}, 32'd0);
    step(); step();
    chk("b stays idle", {29'd0, st_b}, 32'd0);
    chk("b no request idle", {31'd0, if_b.imem_req_valid}, 32'd0);
    run_b = 1'b1;
    step();
    chk("b resume state", {29'd0, st_b}, 32'd1);
    chk("b resume addr", if_b.imem_addr, 32'd0);

    // DUT B: illegal opcode skipped as a NOP
    step();
    if_b.imem_rsp_valid = 1'b1; if_b.imem_rsp_data = BAD;
    step();
    if_b.imem_rsp_valid = 1'b0;
    step();
    chk("b skip to wb", {29'd0, st_b}, 32'd5);
    chk("b skip rf_we", {31'd0, rf_we_b}, 32'd0);
    chk("b skip illegal", {31'd0, ill_b}, 32'd1);
    chk("b skip no halt", {31'd0, halt_b}, 32'd0);
    step();
    chk("b skip continue", {29'd0, st_b}, 32'd1);
    chk("b skip pc", pc_b, 32'd4);
    chk("b skip req", {31'd0, if_b.imem_req_valid}, 32'd1);

    // DUT B: asynchronous reset while in FETCH_WAIT, then a stray response
    step();
    chk("b in fetch_wait", {29'd0, st_b}, 32'd2);
    #2;
    rst_b = 1'b1;
    #1;
    chk("b async rst state", {29'd0, st_b}, 32'd0);
    chk("b async rst instr", instr_b, NOP);
    chk("b async rst pc", pc_b, 32'hFFFF_FFFC);
    chk("b async rst req", {31'd0, if_b.imem_req_valid}, 32'd0);
    chk("b async rst illegal", {31'd0, ill_b}, 32'd0);
`ifdef SEQ_PERF_CNT_EN
    chk("b rst cycle_cnt", cyc_b, 32'd0);
    chk("b rst instret", ret_b, 32'd0);
`endif
    run_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b0;
    if_b.imem_rsp_valid = 1'b1; if_b.imem_rsp_data = ADDI;
    step();
    if_b.imem_rsp_valid = 1'b0;
    chk("b late rsp state", {29'd0, st_b}, 32'd0);
    chk("b late rsp instr", instr_b, NOP);
    step();
    chk("b late rsp idle", {29'd0, st_b}, 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
